// File: rtl/traffic_light_ctrl_if.sv
// Control and status bundle of the intersection controller: run/request inputs,
// signal heads, walk lamp and debug strobes.
interface traffic_light_ctrl_if;
    logic       enable;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_ack;
    logic       tick;
    logic [2:0] state;

    modport master (
        output enable, ped_req,
        input  ns_light, ew_light, walk, ped_ack, tick, state
    );

    modport slave (
        input  enable, ped_req,
        output ns_light, ew_light, walk, ped_ack, tick, state
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Four-way intersection controller with a pedestrian phase. A prescaler makes a
// one-cycle tick; every phase dwell is counted in ticks by a single phase timer.
module traffic_light_ctrl #(
    parameter int TICK_DIV = 12500000,
    parameter int GREEN_T  = 40,
    parameter int YELLOW_T = 12,
    parameter int ALLRED_T = 4,
    parameter int WALK_T   = 24
) (
    input  logic               clk_in,
    input  logic               rst_n,
    traffic_light_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_1 = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_2 = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_t;

    localparam int MAX_GY = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
    localparam int MAX_AW = (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T;
    localparam int MAX_T  = (MAX_GY > MAX_AW) ? MAX_GY : MAX_AW;
    localparam int TW     = $clog2(MAX_T + 1);
    localparam int CW     = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          tick;
    state_t        state_q, state_nxt, target;
    logic [TW-1:0] timer_q, timer_nxt;
    dir_t          next_dir, dir_nxt;
    logic          ped_pending, pend_nxt;
    logic          ack_q, ack_nxt;
    logic          illegal;
    logic [2:0]    ns_light, ew_light;
    logic          walk;

    function automatic logic [TW-1:0] load_val(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   return TW'(GREEN_T - 1);
            NS_YELLOW, EW_YELLOW: return TW'(YELLOW_T - 1);
            PED_WALK:             return TW'(WALK_T - 1);
            default:              return TW'(ALLRED_T - 1);
        endcase
    endfunction

    assign tick = bus.enable && (cnt_q == CNT_MAX);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.enable) begin
            cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q     <= ALL_RED_2;
            timer_q     <= TW'(ALLRED_T - 1);
            next_dir    <= DIR_NS;
            ped_pending <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            timer_q     <= timer_nxt;
            next_dir    <= dir_nxt;
            ped_pending <= pend_nxt;
            ack_q       <= ack_nxt;
        end
    end

    // Branch decisions use the registered pending flag, so a request arriving on
    // the exit tick of an all-red phase waits for the following all-red.
    always_comb begin
        state_nxt = state_q;
        timer_nxt = timer_q;
        dir_nxt   = next_dir;
        pend_nxt  = ped_pending;
        ack_nxt   = 1'b0;
        illegal   = 1'b0;
        target    = state_q;

        case (state_q)
            NS_GREEN:  target = NS_YELLOW;
            NS_YELLOW: target = ALL_RED_1;
            ALL_RED_1: target = ped_pending ? PED_WALK : EW_GREEN;
            EW_GREEN:  target = EW_YELLOW;
            EW_YELLOW: target = ALL_RED_2;
            ALL_RED_2: target = ped_pending ? PED_WALK : NS_GREEN;
            PED_WALK:  target = (next_dir == DIR_EW) ? EW_GREEN : NS_GREEN;
            default: begin
                target  = ALL_RED_2;
                illegal = 1'b1;
            end
        endcase

        if (bus.ped_req && state_q != PED_WALK) begin
            pend_nxt = 1'b1;
        end

        if (illegal) begin
            state_nxt = ALL_RED_2;
            timer_nxt = load_val(ALL_RED_2);
            dir_nxt   = DIR_NS;
        end else if (tick) begin
            if (timer_q == '0) begin
                state_nxt = target;
                timer_nxt = load_val(target);
                if (target == ALL_RED_1) dir_nxt = DIR_EW;
                if (target == ALL_RED_2) dir_nxt = DIR_NS;
                if (target == PED_WALK) begin
                    pend_nxt = 1'b0;
                    ack_nxt  = 1'b1;
                end
            end else begin
                timer_nxt = timer_q - 1'b1;
            end
        end
    end

    // Heads decode from the state register alone; any unknown code shows all red.
    always_comb begin
        ns_light = 3'b100;
        ew_light = 3'b100;
        walk     = 1'b0;
        case (state_q)
            NS_GREEN:  ns_light = 3'b001;
            NS_YELLOW: ns_light = 3'b010;
            EW_GREEN:  ew_light = 3'b001;
            EW_YELLOW: ew_light = 3'b010;
            PED_WALK:  walk     = 1'b1;
            default: begin
                ns_light = 3'b100;
                ew_light = 3'b100;
            end
        endcase
    end

    assign bus.ns_light = ns_light;
    assign bus.ew_light = ew_light;
    assign bus.walk     = walk;
    assign bus.ped_ack  = ack_q;
    assign bus.tick     = tick;
    assign bus.state    = state_q;

endmodule
